// File: rtl/vj_det_collector.sv
// Collects per-frame detections from the sliding-window detector, merging near-duplicates
// into the previous entry, then streams the buffered entries out with a valid/ready handshake.
module vj_det_collector #(
  parameter int MAX_DET    = 16,
  parameter int CNT_W      = 5,
  parameter int MERGE_DIST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             det_busy,
  input  logic             det_valid,
  input  logic [9:0]       det_x,
  input  logic [8:0]       det_y,
  input  logic [9:0]       det_w,
  input  logic [8:0]       det_h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_x,
  output logic [8:0]       out_y,
  output logic [9:0]       out_w,
  output logic [8:0]       out_h,
  output logic [3:0]       out_hits,
  output logic             out_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic             overflow
);

  localparam int IDX_W = (MAX_DET > 1) ? $clog2(MAX_DET) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, READOUT = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [CNT_W-1:0]   frame_count_reg, frame_count_next;
  logic [IDX_W-1:0]   rd_idx_reg, rd_idx_next;
  logic               seen_busy_reg, seen_busy_next;
  logic               overflow_reg, overflow_next;
  logic               done_reg, done_next;
  logic               busy_d_reg;

  logic [9:0]         buf_x    [MAX_DET];
  logic [8:0]         buf_y    [MAX_DET];
  logic [9:0]         buf_w    [MAX_DET];
  logic [8:0]         buf_h    [MAX_DET];
  logic [3:0]         buf_hits [MAX_DET];

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [9:0]         wr_x, wr_w;
  logic [8:0]         wr_y, wr_h;
  logic [3:0]         wr_hits;

  logic [IDX_W-1:0]   last_idx;
  logic [9:0]         dx;
  logic [8:0]         dy;
  logic               mergeable;
  logic               busy_fall;
  logic               xfer;

  assign last_idx  = IDX_W'(count_reg - CNT_W'(1));
  assign busy_fall = !det_busy && seen_busy_reg && busy_d_reg;
  assign xfer      = out_valid && out_ready;

  // Ordered subtraction keeps the distance unsigned without modular wrap at the image edges.
  always_comb begin
    dx = (det_x >= buf_x[last_idx]) ? det_x - buf_x[last_idx] : buf_x[last_idx] - det_x;
    dy = (det_y >= buf_y[last_idx]) ? det_y - buf_y[last_idx] : buf_y[last_idx] - det_y;
    mergeable = (count_reg != '0) && (det_w == buf_w[last_idx]) && (det_h == buf_h[last_idx]) &&
                ({22'd0, dx} <= $unsigned(MERGE_DIST)) && ({23'd0, dy} <= $unsigned(MERGE_DIST));
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_x[wr_idx]    <= wr_x;
      buf_y[wr_idx]    <= wr_y;
      buf_w[wr_idx]    <= wr_w;
      buf_h[wr_idx]    <= wr_h;
      buf_hits[wr_idx] <= wr_hits;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      frame_count_reg <= '0;
      rd_idx_reg      <= '0;
      seen_busy_reg   <= 1'b0;
      overflow_reg    <= 1'b0;
      done_reg        <= 1'b0;
      busy_d_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      frame_count_reg <= frame_count_next;
      rd_idx_reg      <= rd_idx_next;
      seen_busy_reg   <= seen_busy_next;
      overflow_reg    <= overflow_next;
      done_reg        <= done_next;
      busy_d_reg      <= det_busy;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_start) state_next = COLLECT;
      COLLECT: if (!frame_start && busy_fall) state_next = READOUT;
      READOUT: begin
        if (frame_start)                state_next = COLLECT;
        else if (count_reg == '0)       state_next = IDLE;
        else if (xfer && out_last)      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer, counters and completion bookkeeping; frame_start clears everything in any state.
  always_comb begin
    count_next       = count_reg;
    frame_count_next = frame_count_reg;
    rd_idx_next      = rd_idx_reg;
    seen_busy_next   = seen_busy_reg;
    overflow_next    = overflow_reg;
    done_next        = 1'b0;
    wr_en            = 1'b0;
    wr_idx           = count_reg[IDX_W-1:0];
    wr_x             = det_x;
    wr_y             = det_y;
    wr_w             = det_w;
    wr_h             = det_h;
    wr_hits          = 4'd1;
    if (frame_start) begin
      count_next     = '0;
      rd_idx_next    = '0;
      seen_busy_next = 1'b0;
      overflow_next  = 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (det_busy) seen_busy_next = 1'b1;
          if (det_valid) begin
            if (mergeable) begin
              wr_en   = 1'b1;
              wr_idx  = last_idx;
              wr_x    = buf_x[last_idx];
              wr_y    = buf_y[last_idx];
              wr_w    = buf_w[last_idx];
              wr_h    = buf_h[last_idx];
              wr_hits = (buf_hits[last_idx] == 4'hF) ? 4'hF : buf_hits[last_idx] + 4'd1;
            end else if (count_reg < CNT_W'(MAX_DET)) begin
              wr_en      = 1'b1;
              count_next = count_reg + 1'b1;
            end else begin
              overflow_next = 1'b1;
            end
          end
          // An empty frame reports completion in its first readout cycle.
          if (state_next == READOUT && count_next == '0) begin
            done_next        = 1'b1;
            frame_count_next = '0;
          end
        end
        READOUT: begin
          if (xfer) begin
            if (out_last) begin
              done_next        = 1'b1;
              frame_count_next = count_reg;
            end else begin
              rd_idx_next = rd_idx_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid   = (state_reg == READOUT) && (count_reg != '0);
    out_last    = out_valid && (rd_idx_reg == last_idx);
    out_x       = out_valid ? buf_x[rd_idx_reg]    : '0;
    out_y       = out_valid ? buf_y[rd_idx_reg]    : '0;
    out_w       = out_valid ? buf_w[rd_idx_reg]    : '0;
    out_h       = out_valid ? buf_h[rd_idx_reg]    : '0;
    out_hits    = out_valid ? buf_hits[rd_idx_reg] : '0;
    frame_done  = done_reg;
    frame_count = frame_count_reg;
    overflow    = overflow_reg;
  end

endmodule

// File: tb/tb_vj_det_collector.sv
// Randomized scoreboard bench: per-frame detection lists go through a list-based merge model,
// expected entries and frame results are queued, and a negedge monitor checks the DUT output.
module tb_vj_det_collector;
  localparam int MAX_DET    = 16;
  localparam int CNT_W      = 5;
  localparam int MERGE_DIST = 4;

  logic clk = 1'b0, reset_n = 1'b0;
  logic frame_start = 1'b0, det_busy = 1'b0, det_valid = 1'b0, out_ready = 1'b0;
  logic [9:0] det_x = '0, det_w = '0;
  logic [8:0] det_y = '0, det_h = '0;
  logic out_valid, out_last, frame_done, overflow;
  logic [9:0] out_x, out_w;
  logic [8:0] out_y, out_h;
  logic [3:0] out_hits;
  logic [CNT_W-1:0] frame_count;

  typedef struct packed { logic [9:0] x; logic [8:0] y; logic [9:0] w; logic [8:0] h; } det_t;
  typedef struct packed { det_t d; logic [3:0] hits; logic last; } ent_t;
  typedef struct packed { logic [CNT_W-1:0] cnt; logic ovf; } done_t;

  ent_t  exp_ent[$];
  done_t exp_done[$];
  det_t  dets[$];
  int    total = 0, bad = 0;
  int    ready_mode = 1;

  vj_det_collector #(.MAX_DET(MAX_DET), .CNT_W(CNT_W), .MERGE_DIST(MERGE_DIST)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .det_busy(det_busy),
    .det_valid(det_valid), .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_w(out_w), .out_h(out_h), .out_hits(out_hits), .out_last(out_last),
    .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // 0: stalled, 1: always ready, 2: toggling, 3: random
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      total++;
      if ({out_valid, out_last, frame_done, frame_count, overflow, out_x, out_y, out_w, out_h, out_hits} !== '0) begin
        bad++;
        $display("FAIL reset_state: got valid=%0b last=%0b done=%0b cnt=%0d ovf=%0b x=%0d y=%0d w=%0d h=%0d hits=%0d, required all zero",
                 out_valid, out_last, frame_done, frame_count, overflow, out_x, out_y, out_w, out_h, out_hits);
      end
    end else begin
      if (out_valid) begin
        total++;
        if (exp_ent.size() == 0) begin
          bad++;
          $display("FAIL unexpected_entry: got x=%0d y=%0d w=%0d h=%0d hits=%0d, required out_valid=0",
                   out_x, out_y, out_w, out_h, out_hits);
        end else begin
          if ({out_x, out_y, out_w, out_h, out_hits, out_last} !== exp_ent[0]) begin
            bad++;
            $display("FAIL entry: got (%0d,%0d,%0d,%0d) hits=%0d last=%0b, required (%0d,%0d,%0d,%0d) hits=%0d last=%0b",
                     out_x, out_y, out_w, out_h, out_hits, out_last, exp_ent[0].d.x, exp_ent[0].d.y,
                     exp_ent[0].d.w, exp_ent[0].d.h, exp_ent[0].hits, exp_ent[0].last);
          end
          if (out_ready) begin
            $display("entry (%0d,%0d,%0d,%0d) hits=%0d last=%0b", out_x, out_y, out_w, out_h, out_hits, out_last);
            void'(exp_ent.pop_front());
          end
        end
      end
      if (frame_done) begin
        total++;
        if (exp_done.size() == 0 || exp_ent.size() != 0) begin
          bad++;
          $display("FAIL unexpected_done: got frame_done=1 cnt=%0d, required no frame_done (pending entries=%0d)",
                   frame_count, exp_ent.size());
        end else begin
          if ({frame_count, overflow} !== exp_done[0]) begin
            bad++;
            $display("FAIL frame_result: got cnt=%0d ovf=%0b, required cnt=%0d ovf=%0b",
                     frame_count, overflow, exp_done[0].cnt, exp_done[0].ovf);
          end
          $display("frame_done cnt=%0d ovf=%0b", frame_count, overflow);
          void'(exp_done.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_det(input det_t d);
    det_valid = 1'b1;
    det_x = d.x; det_y = d.y; det_w = d.w; det_h = d.h;
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit near(input det_t a, input det_t b);
    return a.w == b.w && a.h == b.h &&
           absdiff(int'(a.x), int'(b.x)) <= MERGE_DIST && absdiff(int'(a.y), int'(b.y)) <= MERGE_DIST;
  endfunction

  function automatic det_t mkdet(input int x, input int y, input int w, input int h);
    det_t d;
    d.x = 10'(x); d.y = 9'(y); d.w = 10'(w); d.h = 9'(h);
    return d;
  endfunction

  function automatic det_t rand_det(input det_t prev, input bit have_prev);
    det_t d;
    int   v;
    if (have_prev && $urandom_range(0, 9) < 6) begin
      d = prev;
      v = int'(prev.x) + int'($urandom_range(0, 12)) - 6;
      d.x = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
      v = int'(prev.y) + int'($urandom_range(0, 12)) - 6;
      d.y = 9'((v < 0) ? 0 : (v > 511) ? 511 : v);
      if ($urandom_range(0, 7) == 0) d.w = prev.w + 10'd1;
    end else begin
      case ($urandom_range(0, 3))
        0:       d.x = 10'($urandom_range(0, 3));
        1:       d.x = 10'($urandom_range(1020, 1023));
        default: d.x = 10'($urandom_range(0, 1023));
      endcase
      d.y = 9'($urandom_range(0, 511));
      d.w = $urandom_range(0, 1) ? 10'd19 : 10'd24;
      d.h = $urandom_range(0, 1) ? 9'd19 : 9'd24;
    end
    return d;
  endfunction

  // Reference: a list of entries, each new detection either merged into the tail or appended.
  task automatic model_push();
    ent_t ents[$];
    ent_t e;
    bit   ovf = 1'b0;
    int   n;
    foreach (dets[i]) begin
      n = ents.size();
      if (n > 0 && near(dets[i], ents[n-1].d)) begin
        e = ents[n-1];
        if (e.hits != 4'd15) e.hits = e.hits + 4'd1;
        ents[n-1] = e;
      end else if (n < MAX_DET) begin
        e.d = dets[i]; e.hits = 4'd1; e.last = 1'b0;
        ents.push_back(e);
      end else begin
        ovf = 1'b1;
      end
    end
    foreach (ents[i]) begin
      e = ents[i];
      e.last = (i == ents.size() - 1);
      exp_ent.push_back(e);
    end
    exp_done.push_back('{cnt: CNT_W'(ents.size()), ovf: ovf});
  endtask

  task automatic wait_done();
    int c = 0;
    while ((exp_ent.size() != 0 || exp_done.size() != 0) && c < 3000) begin
      tick();
      c++;
    end
    total++;
    if (c >= 3000) begin
      bad++;
      $display("FAIL frame_timeout: got %0d entries and %0d results outstanding, required none", exp_ent.size(), exp_done.size());
      exp_ent.delete();
      exp_done.delete();
    end
  endtask

  task automatic run_frame(input int busy_len, input bit coincide, input int rmode, input bit abort, input bit start_junk);
    int idx = 0, cyc = 0, npre;
    det_t junk;
    junk = rand_det(junk, 1'b0);
    ready_mode = abort ? 0 : rmode;
    frame_start = 1'b1;
    if (start_junk) drive_det(junk); else det_valid = 1'b0;
    tick();
    frame_start = 1'b0;
    det_valid = 1'b0;
    det_busy = 1'b1;
    npre = (coincide && dets.size() > 0) ? dets.size() - 1 : dets.size();
    while (cyc < busy_len || idx < npre) begin
      if (idx < npre && $urandom_range(0, 3) != 0) begin
        drive_det(dets[idx]);
        idx++;
      end else begin
        det_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    det_busy = 1'b0;
    if (npre < dets.size()) drive_det(dets[npre]); else det_valid = 1'b0;
    model_push();
    tick();
    det_valid = 1'b0;
    if (!abort) begin
      wait_done();
      drive_det(junk);
      repeat (2) tick();
      det_valid = 1'b0;
    end else begin
      repeat (3) tick();
      frame_start = 1'b1;
      drive_det(junk);
      tick();
      exp_ent.delete();
      exp_done.delete();
      frame_start = 1'b0;
      det_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_valid: got out_valid=%0b, required 0", out_valid);
      end
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    det_t prev;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    dets = '{mkdet(10, 20, 19, 19), mkdet(100, 50, 19, 19)};
    run_frame(100, 1'b0, 1, 1'b0, 1'b0);

    dets = '{mkdet(10, 20, 19, 19), mkdet(12, 22, 19, 19), mkdet(14, 24, 19, 19), mkdet(10, 25, 19, 19)};
    run_frame(10, 1'b0, 2, 1'b0, 1'b0);

    dets = '{mkdet(1, 5, 19, 19), mkdet(1022, 5, 19, 19), mkdet(1022, 5, 24, 19), mkdet(1022, 5, 24, 19)};
    run_frame(8, 1'b1, 1, 1'b0, 1'b1);

    dets.delete();
    for (int i = 0; i < MAX_DET + 3; i++) dets.push_back(mkdet(i * 50, i * 20, 19, 19));
    run_frame(30, 1'b1, 2, 1'b0, 1'b0);

    dets.delete();
    for (int i = 0; i < 20; i++) dets.push_back(mkdet(300, 100, 24, 24));
    run_frame(25, 1'b1, 3, 1'b0, 1'b1);

    dets.delete();
    run_frame(10, 1'b0, 1, 1'b0, 1'b0);

    dets = '{mkdet(5, 5, 19, 19), mkdet(200, 5, 19, 19), mkdet(400, 5, 19, 19), mkdet(600, 5, 19, 19)};
    run_frame(10, 1'b0, 0, 1'b1, 1'b0);
    dets = '{mkdet(700, 300, 24, 24)};
    run_frame(5, 1'b0, 1, 1'b0, 1'b0);

    // Reset in the middle of collection: nothing from that frame may come out.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    det_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin drive_det(mkdet(i * 100, 10, 19, 19)); tick(); end
    det_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    det_busy = 1'b0;
    repeat (3) tick();
    dets = '{mkdet(50, 60, 19, 19)};
    run_frame(4, 1'b0, 1, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      dets.delete();
      for (int i = 0; i < int'($urandom_range(0, 22)); i++) begin
        prev = rand_det(prev, dets.size() > 0);
        dets.push_back(prev);
      end
      run_frame(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
